gpu_mem_arbiter: RTL and testbench
==================================

# gpu_mem_arbiter

Shares the GPU's single-port 16-bit program/data memory between several requesters: instruction fetch, load/store unit and shader-binary loader. It takes at most one access per cycle, round-robin by default, and supports locked bursts so fetch can stream consecutive instruction words. The memory has a 1-cycle registered read: address in cycle N, data valid in N+1. The arbiter routes that returned word back to the requester that issued the read.

## Interface
- NUM_REQ, 3, number of requesters (2..8); index 0 = fetch, 1 = load/store, 2 = loader
- ADDR_W, 20, memory address width
- DATA_W, 16, memory word width
- MAX_BURST, 16, maximum consecutive grants to one locked owner (2..256)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-requester access request, held until granted
- lock  in  NUM_REQ  per-requester burst lock, sampled with req
- we  in  NUM_REQ  1 = write, 0 = read
- addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- gnt  out  NUM_REQ  one-hot grant, combinational, at most one bit set
- rvalid  out  NUM_REQ  one-hot read-data-valid, registered
- rdata  out  DATA_W  read data, broadcast to all requesters; qualified by rvalid
- owner  out  $clog2(NUM_REQ)  index of current/last grantee, registered
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr

## Operation
- Requester i raises req[i] with addr/we/wdata stable and holds them until it samples gnt[i]=1. The access happens in that cycle.
- req must not depend combinationally on gnt.
- When gnt[i]=1:
  - mem_addr = addr[i], mem_we = we[i], mem_wdata = wdata[i].
  - With no grant: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Reads: the winning index is registered, and in the next cycle rvalid[that index] = 1 with rdata = mem_rdata. Writes never produce rvalid.
- FSM state ARB:
  - Winner is the first set req bit scanning from rr_ptr upward, with wrap-around.
  - On a grant, rr_ptr <= (winner+1) mod NUM_REQ.
  - If lock[winner]=1, go to LOCKED with burst_cnt <= 1 and owner <= winner.
- FSM state LOCKED:
  - Only owner can be granted; others see gnt=0.
  - If req[owner]=1 and lock[owner]=1 and burst_cnt < MAX_BURST: grant owner, burst_cnt++.
  - If req[owner]=1, lock[owner]=0 and burst_cnt < MAX_BURST: grant owner as the final beat, then go to ARB.
  - If req[owner]=0 (lock ignored): no grant this cycle, go to ARB. Arbitration resumes next cycle.
  - If burst_cnt == MAX_BURST: forced release. No grant this cycle, go to ARB. rr_ptr stays at owner+1, so the owner cannot immediately re-win unless it is the only requester.
- In ARB, one grant per cycle whenever any req is set. Back-to-back grants to different requesters are allowed.
- With a single active requester, throughput is 1 access per cycle.

## Timing
- Reset (rst=1 at an edge): state = ARB, rr_ptr = 0, burst_cnt = 0, owner = 0, rvalid = 0. gnt follows the combinational rules, but mem_we is forced to 0 and gnt to 0 while rst=1.
- Reset mid-operation: the rvalid for a read granted in the reset cycle or the cycle before is squashed. A burst in progress is abandoned.
- Read latency: gnt in cycle N gives rvalid/rdata in cycle N+1. rdata is passthrough of mem_rdata, with no extra register.
- Write: commits at the clock edge ending the gnt cycle.
- A read granted in N and a write granted in N+1 both proceed; the read data in N+1 is unaffected.
- rvalid holds for exactly one cycle per granted read.
- Simultaneous requests: exactly one winner, by rr_ptr order. Losers are not acknowledged and must keep req high.
- A lock asserted by a losing requester has no effect.

## Test plan
- Reset then idle: rst=1 for 2 cycles, all req=0 -> gnt=0, rvalid=0, mem_we=0, mem_addr=0, owner=0.
- Single read: req[0]=1, addr=0x00010, mem model returns 0xBEEF -> gnt=001 in cycle N, rvalid=001 with rdata=0xBEEF in N+1, no other rvalid.
- Round-robin fairness: req=111 held for 6 cycles, all reads, no lock -> grant order 0,1,2,0,1,2, with rvalid following one cycle later in the same order.
- Locked fetch burst: req[0]=lock[0]=1 at addr 0..3, lock drops on the 4th beat, req[1]=1 throughout -> four gnt[0] in a row, then gnt[1], 4 rvalids to requester 0 with the correct data.
- Burst limit: MAX_BURST=16, requester 0 locked indefinitely, req[2]=1 -> 16 gnt[0], one idle cycle, then gnt[2] before requester 0 is granted again.
- Write then read, plus reset mid-burst: requester 2 writes 0x1234 to 0x00100, requester 1 reads 0x00100 -> rdata=0x1234. A later rst=1 during a locked read burst -> no rvalid in the following cycle, state = ARB.

Source files
------------

// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter: single-port memory arbiter for fetch, load/store and loader.
// Round-robin selection with optional locked bursts (bounded by MAX_BURST);
// read data returns one cycle after the grant and is steered back to the
// requester that issued the read via a one-hot rvalid.
module gpu_mem_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    input  logic [NUM_REQ-1:0]         we,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
    logic [NUM_REQ-1:0] rvalid_reg, rvalid_next;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_idx;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    // Per-requester unpacking, one-hot grant decode and read-return tagging.
    // rvalid is masked by rst so a read granted just before reset never returns.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign addr_arr[gi]    = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]   = wdata[gi*DATA_W +: DATA_W];
            assign gnt[gi]         = gnt_any && (gnt_idx == IDX_W'(gi));
            assign rvalid_next[gi] = gnt[gi] && !we[gi];
            assign rvalid[gi]      = rvalid_reg[gi] && !rst;
        end
    endgenerate

    assign rdata = mem_rdata;
    assign owner = owner_reg;

    // Round-robin pick: first asserted req scanning upward from rr_ptr, wrapping.
    always_comb begin
        int cand;
        cand     = 0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!rr_found && req[IDX_W'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(cand);
            end
        end
    end

    // Next-state and grant decision; in LOCKED only the owner may be granted.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        gnt_any        = 1'b0;
        gnt_idx        = '0;
        case (state_reg)
            ST_ARB: begin
                if (rr_found) begin
                    gnt_any     = 1'b1;
                    gnt_idx     = rr_idx;
                    owner_next  = rr_idx;
                    rr_ptr_next = (rr_idx == LAST_IDX) ? '0 : rr_idx + 1'b1;
                    if (lock[rr_idx]) begin
                        state_next     = ST_LOCKED;
                        burst_cnt_next = CNT_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                // Dropped request or exhausted burst both release without a grant;
                // rr_ptr already points past the owner, so others get the next turn.
                if (req[owner_reg] && (burst_cnt_reg < MAX_CNT)) begin
                    gnt_any = 1'b1;
                    gnt_idx = owner_reg;
                    if (lock[owner_reg]) begin
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                    end else begin
                        state_next = ST_ARB;
                    end
                end else begin
                    state_next = ST_ARB;
                end
            end
            default: begin
                state_next = ST_ARB;
            end
        endcase
        if (rst) begin
            gnt_any = 1'b0;
        end
    end

    // Memory port mux: driven from the granted requester, zero when idle.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (gnt_any) begin
            mem_addr  = addr_arr[gnt_idx];
            mem_we    = we[gnt_idx];
            mem_wdata = wdata_arr[gnt_idx];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_ARB;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
            rvalid_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
            rvalid_reg    <= rvalid_next;
        end
    end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// tb_gpu_mem_arbiter: scenario tasks with a read-return scoreboard and a
// small registered-read memory model attached to the memory port.
module tb_gpu_mem_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 16;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req, lock, we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt, rvalid;
    logic [DATA_W-1:0]         rdata, mem_wdata, mem_rdata;
    logic [1:0]                owner;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_we;

    logic                      pre_we = 1'b0;
    logic [11:0]               pre_addr = '0;
    logic [15:0]               pre_data = '0;
    logic [15:0]               mem_model [0:4095];

    typedef struct {
        int          idx;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [2:0]  exp_rv;
    logic [15:0] exp_rd;

    gpu_mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .owner(owner),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read; preload port used only while idle.
    always @(posedge clk) begin
        if (pre_we) mem_model[pre_addr] <= pre_data;
        else if (mem_we) mem_model[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= mem_model[mem_addr[11:0]];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_port(input int i, input logic r, input logic l, input logic w,
                            input logic [19:0] a, input logic [15:0] d);
        req[i]                    = r;
        lock[i]                   = l;
        we[i]                     = w;
        addr[i*ADDR_W +: ADDR_W]  = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_all();
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        next_cycle();
        pre_we = 1'b0;
    endtask

    task automatic push_read(input int i, input logic [15:0] d);
        exp_t e;
        e.idx = i; e.data = d; e.due = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Expected rvalid/rdata for the current cycle, taken from the scoreboard.
    function automatic void pop_expected(output logic [2:0] rv, output logic [15:0] rd);
        rv = 3'b000;
        rd = 16'h0000;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            rv = 3'b001 << exp_q[0].idx;
            rd = exp_q[0].data;
            void'(exp_q.pop_front());
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        @(negedge clk);
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
        n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        n_checks++; if (mem_addr !== 20'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 00000", mem_addr); end
        next_cycle();
        set_port(2, 1'b1, 1'b1, 1'b1, 20'h00055, 16'hDEAD);
        @(negedge clk);
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_req_gnt: got %b expected 000", gnt); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_req_mem_we: got %b expected 0", mem_we); end
        next_cycle();
        rst = 1'b0;
        clear_all();
        @(negedge clk);
        n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL idle_gnt: got %b expected 000", gnt); end
        n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL idle_rvalid: got %b expected 000", rvalid); end
        n_checks++; if (mem_addr !== 20'h0) begin n_fail++; $display("FAIL idle_mem_addr: got %h expected 00000", mem_addr); end
        next_cycle();
        $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_single_read();
        preload(12'h010, 16'hBEEF);
        set_port(0, 1'b1, 1'b0, 1'b0, 20'h00010, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            pop_expected(exp_rv, exp_rd);
            n_checks++;
            if (rvalid !== exp_rv || (exp_rv !== 3'b000 && rdata !== exp_rd)) begin
                n_fail++; $display("FAIL single_rvalid: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", rvalid, rdata, exp_rv, exp_rd);
            end
            n_checks++;
            if (gnt !== ((c == 0) ? 3'b001 : 3'b000)) begin
                n_fail++; $display("FAIL single_gnt: cycle %0d got %b", c, gnt);
            end
            if (c == 0) begin
                n_checks++;
                if (mem_addr !== 20'h00010 || mem_we !== 1'b0) begin
                    n_fail++; $display("FAIL single_mem: got addr=%h we=%b expected addr=00010 we=0", mem_addr, mem_we);
                end
                push_read(0, 16'hBEEF);
            end
            next_cycle();
            clear_all();
        end
        $display("test_single_read done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        for (int i = 0; i < 3; i++) preload(12'(32'h200 + i), 16'(32'hA000 + i));
        for (int i = 0; i < 3; i++) set_port(i, 1'b1, 1'b0, 1'b0, 20'(32'h200 + i), 16'h0000);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pop_expected(exp_rv, exp_rd);
            n_checks++;
            if (rvalid !== exp_rv || (exp_rv !== 3'b000 && rdata !== exp_rd)) begin
                n_fail++; $display("FAIL rr_rvalid: cycle %0d got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, exp_rv, exp_rd);
            end
            if (c < 6) begin
                e = c % 3;
                n_checks++;
                if (gnt !== (3'b001 << e) || mem_addr !== 20'(32'h200 + e)) begin
                    n_fail++; $display("FAIL rr_gnt: cycle %0d got gnt=%b addr=%h expected gnt=%b addr=%h", c, gnt, mem_addr, 3'b001 << e, 20'(32'h200 + e));
                end
                push_read(e, 16'(32'hA000 + e));
            end else begin
                n_checks++;
                if (gnt !== 3'b000) begin n_fail++; $display("FAIL rr_idle_gnt: cycle %0d got %b expected 000", c, gnt); end
            end
            if (c > 0 && c < 7) begin
                n_checks++;
                if (owner !== 2'((c - 1) % 3)) begin
                    n_fail++; $display("FAIL rr_owner: cycle %0d got %0d expected %0d", c, owner, (c - 1) % 3);
                end
            end
            next_cycle();
            if (c == 5) clear_all();
        end
        $display("test_round_robin done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_locked_burst();
        logic [2:0] eg;
        do_reset();
        for (int k = 0; k < 4; k++) preload(12'(k), 16'(32'h1100 + k));
        preload(12'h300, 16'h3333);
        for (int c = 0; c < 8; c++) begin
            if (c < 4) set_port(0, 1'b1, (c < 3), 1'b0, 20'(c), 16'h0000);
            else set_port(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0000);
            // requester 1 holds a lock while losing; it must not steal the burst
            if (c < 5) set_port(1, 1'b1, 1'b1, 1'b0, 20'h00300, 16'h0000);
            else set_port(1, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0000);
            @(negedge clk);
            pop_expected(exp_rv, exp_rd);
            n_checks++;
            if (rvalid !== exp_rv || (exp_rv !== 3'b000 && rdata !== exp_rd)) begin
                n_fail++; $display("FAIL burst_rvalid: cycle %0d got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, exp_rv, exp_rd);
            end
            eg = (c < 4) ? 3'b001 : ((c == 4) ? 3'b010 : 3'b000);
            n_checks++;
            if (gnt !== eg) begin n_fail++; $display("FAIL burst_gnt: cycle %0d got %b expected %b", c, gnt, eg); end
            if (c < 4) begin
                n_checks++;
                if (mem_addr !== 20'(c)) begin n_fail++; $display("FAIL burst_addr: cycle %0d got %h expected %h", c, mem_addr, 20'(c)); end
                push_read(0, 16'(32'h1100 + c));
            end
            if (c == 4) push_read(1, 16'h3333);
            next_cycle();
        end
        $display("test_locked_burst done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_burst_limit();
        logic [2:0] eg;
        do_reset();
        preload(12'h400, 16'h4444);
        preload(12'h402, 16'h4242);
        set_port(0, 1'b1, 1'b1, 1'b0, 20'h00400, 16'h0000);
        set_port(2, 1'b1, 1'b0, 1'b0, 20'h00402, 16'h0000);
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            pop_expected(exp_rv, exp_rd);
            n_checks++;
            if (rvalid !== exp_rv || (exp_rv !== 3'b000 && rdata !== exp_rd)) begin
                n_fail++; $display("FAIL limit_rvalid: cycle %0d got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, exp_rv, exp_rd);
            end
            if (c < MAX_BURST) eg = 3'b001;
            else if (c == MAX_BURST) eg = 3'b000;
            else if (c == MAX_BURST + 1) eg = 3'b100;
            else if (c == MAX_BURST + 2) eg = 3'b001;
            else eg = 3'b000;
            n_checks++;
            if (gnt !== eg) begin n_fail++; $display("FAIL limit_gnt: cycle %0d got %b expected %b", c, gnt, eg); end
            if (eg == 3'b001) push_read(0, 16'h4444);
            if (eg == 3'b100) push_read(2, 16'h4242);
            next_cycle();
            if (c == MAX_BURST + 1) set_port(2, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0000);
            if (c == MAX_BURST + 2) set_port(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0000);
        end
        $display("test_burst_limit done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_write_read();
        logic [2:0] eg;
        clear_all();
        for (int c = 0; c < 6; c++) begin
            clear_all();
            case (c)
                0: set_port(2, 1'b1, 1'b0, 1'b1, 20'h00100, 16'h1234);
                1: set_port(1, 1'b1, 1'b0, 1'b0, 20'h00100, 16'h0000);
                2: set_port(2, 1'b1, 1'b0, 1'b1, 20'h00100, 16'h5678);
                3: set_port(0, 1'b1, 1'b0, 1'b0, 20'h00100, 16'h0000);
                default: ;
            endcase
            @(negedge clk);
            pop_expected(exp_rv, exp_rd);
            n_checks++;
            if (rvalid !== exp_rv || (exp_rv !== 3'b000 && rdata !== exp_rd)) begin
                n_fail++; $display("FAIL wr_rvalid: cycle %0d got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, exp_rv, exp_rd);
            end
            case (c)
                0, 2: eg = 3'b100;
                1: eg = 3'b010;
                3: eg = 3'b001;
                default: eg = 3'b000;
            endcase
            n_checks++;
            if (gnt !== eg || mem_we !== (c == 0 || c == 2)) begin
                n_fail++; $display("FAIL wr_gnt: cycle %0d got gnt=%b we=%b expected gnt=%b we=%b", c, gnt, mem_we, eg, (c == 0 || c == 2));
            end
            if (c == 0) begin
                n_checks++;
                if (mem_addr !== 20'h00100 || mem_wdata !== 16'h1234) begin
                    n_fail++; $display("FAIL wr_port: got addr=%h wdata=%h expected addr=00100 wdata=1234", mem_addr, mem_wdata);
                end
            end
            if (c == 1) push_read(1, 16'h1234);
            if (c == 3) push_read(0, 16'h5678);
            next_cycle();
        end
        $display("test_write_read done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int k = 0; k < 4; k++) preload(12'(32'h500 + k), 16'(32'h5500 + k));
        preload(12'h600, 16'h6666);
        for (int c = 0; c < 7; c++) begin
            clear_all();
            if (c < 4) set_port(0, 1'b1, 1'b1, 1'b0, 20'(32'h500 + c), 16'h0000);
            if (c == 4) set_port(1, 1'b1, 1'b0, 1'b0, 20'h00600, 16'h0000);
            rst = (c == 3);
            @(negedge clk);
            pop_expected(exp_rv, exp_rd);
            n_checks++;
            if (rvalid !== exp_rv || (exp_rv !== 3'b000 && rdata !== exp_rd)) begin
                n_fail++; $display("FAIL rstb_rvalid: cycle %0d got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, exp_rv, exp_rd);
            end
            n_checks++;
            if (gnt !== ((c < 3) ? 3'b001 : ((c == 4) ? 3'b010 : 3'b000))) begin
                n_fail++; $display("FAIL rstb_gnt: cycle %0d got %b", c, gnt);
            end
            if (c == 3) begin
                n_checks++;
                if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstb_mem_we: got %b expected 0", mem_we); end
            end
            if (c == 4) begin
                n_checks++;
                if (owner !== 2'd0) begin n_fail++; $display("FAIL rstb_owner: got %0d expected 0", owner); end
                push_read(1, 16'h6666);
            end
            // the read granted at c==2 returns in the reset cycle and is squashed
            if (c < 2) push_read(0, 16'(32'h5500 + c));
            next_cycle();
        end
        rst = 1'b0;
        $display("test_reset_mid_burst done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    initial begin
        clear_all();
        test_reset();
        test_single_read();
        test_round_robin();
        test_locked_burst();
        test_burst_limit();
        test_write_read();
        test_reset_mid_burst();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending reads expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit expired expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
